// File: rtl/sd_sector_streamer.sv
// ---------------------------------------------------------------------------
// sd_sector_streamer
//
// Sequences multi-sector reads on the SPI sd_controller and converts its
// byte_available strobes into a buffered valid/ready byte stream for the
// image loader. Runs entirely in the sd_controller clock domain.
//
// Ports:
//   clk               controller clock, all logic on the rising edge
//   reset             synchronous, active-low (0 = reset)
//   start             one-cycle pulse, accepted only in IDLE or DONE
//   start_addr        byte address of the first sector (latched on start)
//   num_sectors       number of sectors to read (latched on start)
//   sd_ready          sd_controller ready
//   sd_byte_available sd_controller byte strobe (may stay high several cycles)
//   sd_dout           sd_controller data byte
//   sd_rd             read request to sd_controller (only high in ISSUE)
//   sd_addr           sector byte address to sd_controller
//   out_data          registered FIFO head byte
//   out_valid         FIFO not empty
//   out_ready         consumer accepts head when out_valid & out_ready
//   busy              transfer in progress
//   done              level, transfer finished and stream drained
//   overflow          sticky, a byte arrived while the FIFO was full
//   byte_count        bytes captured in this transfer (saturating)
// ---------------------------------------------------------------------------
module sd_sector_streamer #(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_STEP    = 512,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [15:0] num_sectors,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [23:0] byte_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SEC_W = $clog2(SECTOR_BYTES);

    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [SEC_W-1:0] LAST_BYTE = SEC_W'(SECTOR_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        ISSUE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             avail_prev;

    logic [SEC_W-1:0] sector_bytes;
    logic [15:0]      sector_idx;
    logic [15:0]      sector_total;
    logic [31:0]      sector_addr;

    logic             capture;
    logic             full;
    logic             rd_en;
    logic             wr_en;
    logic             drop;
    logic [PTR_W:0]   count_next;
    logic [PTR_W:0]   remaining;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [7:0]       head_next;

    // Edge-detect the byte strobe so a long-held strobe yields one capture.
    // Captures outside STREAM are ignored so stray strobes cannot pollute
    // the stream or the counters.
    assign capture = sd_byte_available & ~avail_prev & (state == STREAM);

    assign full        = (count == FIFO_FULL);
    assign rd_en       = out_valid & out_ready;
    // A read in the same cycle frees a slot, so a write into a full FIFO
    // still succeeds when the consumer pops.
    assign wr_en       = capture & (~full | rd_en);
    assign drop        = capture & full & ~rd_en;
    assign count_next  = count + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_en);
    assign remaining   = count - (PTR_W + 1)'(rd_en);
    assign rd_ptr_next = rd_ptr + PTR_W'(rd_en);

    // Next head byte: when nothing else is queued the incoming byte becomes
    // the head directly (bypassing the array), otherwise the array entry at
    // the advanced read pointer. That entry cannot be the one being written
    // this cycle unless the FIFO is otherwise empty, which the bypass covers.
    always_comb begin
        head_next = out_data;
        if (remaining == '0) begin
            if (wr_en) begin
                head_next = sd_dout;
            end
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Storage array; contents need no reset since validity is tracked by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sd_dout;
        end
    end

    // FIFO pointers, occupancy and the registered head.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            avail_prev <= 1'b0;
        end else begin
            avail_prev <= sd_byte_available;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            out_data  <= head_next;
        end
    end

    // Transfer sequencer. sd_addr is loaded only when entering ISSUE so it
    // holds steady for the controller; sector_addr tracks the next sector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            sd_rd        <= 1'b0;
            sd_addr      <= 32'h0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            byte_count   <= 24'h0;
            sector_bytes <= '0;
            sector_idx   <= 16'h0;
            sector_total <= 16'h0;
            sector_addr  <= 32'h0;
        end else begin
            if (capture && byte_count != 24'hFFFFFF) begin
                byte_count <= byte_count + 24'h1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sector_addr  <= start_addr;
                        sector_total <= num_sectors;
                        sector_idx   <= 16'h0;
                        sector_bytes <= '0;
                        byte_count   <= 24'h0;
                        overflow     <= 1'b0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        // An empty request still passes through DRAIN so
                        // done rises through the normal completion path.
                        state        <= (num_sectors == 16'h0) ? DRAIN : WAIT_READY;
                    end
                end

                WAIT_READY: begin
                    if (sd_ready) begin
                        sd_rd   <= 1'b1;
                        sd_addr <= sector_addr;
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    // The controller drops ready once it has taken the request.
                    if (!sd_ready) begin
                        sd_rd <= 1'b0;
                        state <= STREAM;
                    end
                end

                STREAM: begin
                    if (capture) begin
                        if (sector_bytes == LAST_BYTE) begin
                            sector_bytes <= '0;
                            sector_idx   <= sector_idx + 16'h1;
                            if (sector_idx + 16'h1 == sector_total) begin
                                state <= DRAIN;
                            end else begin
                                sector_addr <= sector_addr + 32'(ADDR_STEP);
                                state       <= WAIT_READY;
                            end
                        end else begin
                            sector_bytes <= sector_bytes + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (count == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_streamer.sv
// ---------------------------------------------------------------------------
// tb_sd_sector_streamer
//
// Directed self-checking bench for sd_sector_streamer. A small behavioural
// model of the sd_controller answers read requests with byte strobes; a
// negedge monitor records every byte the consumer accepts, and the expected
// stream is built alongside the stimulus.
// ---------------------------------------------------------------------------
module tb_sd_sector_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'h0;
    logic [15:0] num_sectors = 16'h0;
    logic        sd_ready = 1'b1;
    logic        sd_byte_available = 1'b0;
    logic [7:0]  sd_dout = 8'h00;
    logic        out_ready = 1'b1;
    logic        sd_rd;
    logic [31:0] sd_addr;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [23:0] byte_count;

    int n_asserts = 0;
    int n_fail = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         got_base = 0;

    sd_sector_streamer #(
        .SECTOR_BYTES(512),
        .ADDR_STEP(512),
        .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .num_sectors(num_sectors),
        .sd_ready(sd_ready),
        .sd_byte_available(sd_byte_available),
        .sd_dout(sd_dout),
        .sd_rd(sd_rd),
        .sd_addr(sd_addr),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Record every byte the consumer accepts.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got.push_back(out_data);
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_sd_rd"}, 32'(sd_rd), 32'h0);
        check_output({tag, "_sd_addr"}, sd_addr, 32'h0);
        check_output({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check_output({tag, "_out_data"}, 32'(out_data), 32'h0);
        check_output({tag, "_busy"}, 32'(busy), 32'h0);
        check_output({tag, "_done"}, 32'(done), 32'h0);
        check_output({tag, "_overflow"}, 32'(overflow), 32'h0);
        check_output({tag, "_byte_count"}, 32'(byte_count), 32'h0);
    endtask

    task automatic begin_test();
        exp_q.delete();
        got_base = got.size();
    endtask

    task automatic apply_start(input logic [31:0] addr, input logic [15:0] n);
        step();
        start       = 1'b1;
        start_addr  = addr;
        num_sectors = n;
        step();
        start       = 1'b0;
    endtask

    task automatic emit_byte(input logic [7:0] v, input int hold);
        step();
        sd_dout           = v;
        sd_byte_available = 1'b1;
        repeat (hold) step();
        sd_byte_available = 1'b0;
    endtask

    // Controller model for one sector: wait for the request, accept it,
    // stream 512 bytes of value base+i. Optional stall of the consumer for
    // the first 'stall' strobes, a rogue start pulse before byte inject_idx,
    // and a one-cycle reset before byte reset_idx (which ends the sector).
    task automatic send_sector(input string tag, input logic [31:0] exp_addr,
                               input logic [7:0] base, input int hold,
                               input int stall, input int inject_idx,
                               input int reset_idx);
        int n = 0;
        logic [7:0] v;
        while (sd_rd !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check_output({tag, "_rd_seen"}, 32'(sd_rd), 32'h1);
        check_output({tag, "_addr"}, sd_addr, exp_addr);
        step();
        sd_ready = 1'b0;
        step();
        step();
        check_output({tag, "_rd_dropped"}, 32'(sd_rd), 32'h0);
        if (stall > 0) out_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            if (i == reset_idx) begin
                step();
                reset = 1'b0;
                step();
                reset = 1'b1;
                return;
            end
            if (i == inject_idx) begin
                step();
                start       = 1'b1;
                start_addr  = 32'hDEAD0000;
                num_sectors = 16'd1;
                step();
                start       = 1'b0;
            end
            v = base + 8'(i);
            emit_byte(v, hold);
            if (stall == 0 || i < 16 || i >= stall) exp_q.push_back(v);
            if (stall > 0 && i == 15) check_output({tag, "_ovf_at16"}, 32'(overflow), 32'h0);
            if (stall > 0 && i == 16) check_output({tag, "_ovf_at17"}, 32'(overflow), 32'h1);
            if (stall > 0 && i == stall - 1) begin
                check_output({tag, "_held_valid"}, 32'(out_valid), 32'h1);
                out_ready = 1'b1;
            end
        end
        step();
        step();
        step();
        check_output({tag, "_rd_between"}, 32'(sd_rd), 32'h0);
        sd_ready = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check_output({tag, "_done"}, 32'(done), 32'h1);
        check_output({tag, "_busy_low"}, 32'(busy), 32'h0);
    endtask

    task automatic check_stream(input string tag);
        int n;
        int bad = 0;
        n = got.size() - got_base;
        check_output({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            if (got[got_base + i] !== exp_q[i]) bad++;
        end
        check_output({tag, "_data"}, 32'(bad), 32'h0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b1;
        step();

        // Single sector, bytes 0x00..0xFF twice
        begin_test();
        apply_start(32'h400, 16'd1);
        check_output("t1_busy", 32'(busy), 32'h1);
        send_sector("t1s0", 32'h400, 8'h00, 1, 0, -1, -1);
        wait_done("t1");
        check_stream("t1");
        check_output("t1_count", 32'(byte_count), 32'd512);
        check_output("t1_ovf", 32'(overflow), 32'h0);

        // Three sectors from address 0
        begin_test();
        apply_start(32'h0, 16'd3);
        check_output("t2_done_dropped", 32'(done), 32'h0);
        send_sector("t2s0", 32'h000, 8'h10, 1, 0, -1, -1);
        send_sector("t2s1", 32'h200, 8'h20, 1, 0, -1, -1);
        send_sector("t2s2", 32'h400, 8'h30, 1, 0, -1, -1);
        wait_done("t2");
        check_stream("t2");
        check_output("t2_count", 32'(byte_count), 32'd1536);

        // Consumer stalled for 20 strobes
        begin_test();
        apply_start(32'h2000, 16'd1);
        send_sector("t3s0", 32'h2000, 8'h40, 1, 20, -1, -1);
        wait_done("t3");
        check_stream("t3");
        check_output("t3_count", 32'(byte_count), 32'd512);
        check_output("t3_ovf", 32'(overflow), 32'h1);

        // Strobe held high for 4 cycles per byte
        begin_test();
        apply_start(32'h600, 16'd1);
        check_output("t4_ovf_cleared", 32'(overflow), 32'h0);
        send_sector("t4s0", 32'h600, 8'h77, 4, 0, -1, -1);
        wait_done("t4");
        check_stream("t4");
        check_output("t4_count", 32'(byte_count), 32'd512);

        // Zero-sector request
        begin_test();
        apply_start(32'h1234, 16'd0);
        check_output("t5_done_low", 32'(done), 32'h0);
        check_output("t5_busy", 32'(busy), 32'h1);
        step();
        check_output("t5_done", 32'(done), 32'h1);
        check_output("t5_no_rd", 32'(sd_rd), 32'h0);
        check_output("t5_count", 32'(byte_count), 32'h0);

        // Start pulse during STREAM is ignored
        begin_test();
        apply_start(32'h1000, 16'd2);
        send_sector("t6s0", 32'h1000, 8'h05, 1, 0, 10, -1);
        send_sector("t6s1", 32'h1200, 8'h85, 1, 0, -1, -1);
        wait_done("t6");
        check_stream("t6");
        check_output("t6_count", 32'(byte_count), 32'd1024);

        // Reset at byte 100 of sector 0, controller still busy afterwards
        begin_test();
        apply_start(32'h800, 16'd1);
        send_sector("t7s0", 32'h800, 8'h00, 1, 0, -1, 100);
        check_reset_outputs("t7_mid_reset");
        begin_test();
        apply_start(32'h3000, 16'd1);
        repeat (5) step();
        check_output("t7_wait_ready", 32'(sd_rd), 32'h0);
        sd_ready = 1'b1;
        send_sector("t7s1", 32'h3000, 8'hA0, 1, 0, -1, -1);
        wait_done("t7");
        check_stream("t7");
        check_output("t7_count", 32'(byte_count), 32'd512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
